pll_reconfig_ctrl: RTL and testbench

Sequencer for the target-clock PLL. It takes one reconfiguration request at a time, loads the 16-bit configuration word and pulses the trigger. It then holds the PLL in reset, selects the input clock, and waits for a stable lock within a bounded time. The block sits between the stimulus sequencer and the PLL pins, replacing ad-hoc toggling of pll_reset, pll_data, pll_trigger and pll_switch.

---
 rtl/test_ctrl_pkg.sv | 34 +++
 rtl/sync_2ff.sv | 27 ++
 rtl/pll_reconfig_ctrl.sv | 167 ++++++++++++++++
 tb/tb_pll_reconfig_ctrl.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/test_ctrl_pkg.sv
// Shared constants and state encoding for the PLL reconfiguration sequencer
// and the stimulus code that drives it.
package test_ctrl_pkg;

    localparam int PLL_DATA_WIDTH     = 16;
    localparam int DEF_RESET_CYCLES   = 8;
    localparam int DEF_SETTLE_CYCLES  = 4;
    localparam int DEF_TIMEOUT_WIDTH  = 16;
    localparam int DEF_LOCK_TIMEOUT   = 65535;

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_LOAD      = 3'd1;
    localparam logic [2:0] ST_TRIGGER   = 3'd2;
    localparam logic [2:0] ST_HOLD_RST  = 3'd3;
    localparam logic [2:0] ST_WAIT_LOCK = 3'd4;
    localparam logic [2:0] ST_DONE      = 3'd5;
    localparam logic [2:0] ST_FAIL      = 3'd6;

    typedef enum logic [2:0] {
        S_IDLE      = ST_IDLE,
        S_LOAD      = ST_LOAD,
        S_TRIGGER   = ST_TRIGGER,
        S_HOLD_RST  = ST_HOLD_RST,
        S_WAIT_LOCK = ST_WAIT_LOCK,
        S_DONE      = ST_DONE,
        S_FAIL      = ST_FAIL
    } state_t;

    // Larger of two integers, used to size the shared cycle counters.
    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchronizer for slow-changing asynchronous status bits.
module sync_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta_r;
    logic [WIDTH-1:0] sync_r;

    // Two back-to-back flops give metastability a full cycle to resolve.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            meta_r <= {WIDTH{1'b0}};
            sync_r <= {WIDTH{1'b0}};
        end else begin
            meta_r <= d;
            sync_r <= meta_r;
        end
    end

    assign q = sync_r;

endmodule

// File: rtl/pll_reconfig_ctrl.sv
// Sequencer that loads a configuration word into the target-clock PLL,
// strobes the trigger, holds the PLL in reset, selects its input clock
// and then waits a bounded time for a stable lock.
module pll_reconfig_ctrl import test_ctrl_pkg::*; #(
    parameter int                       RESET_CYCLES  = DEF_RESET_CYCLES,
    parameter int                       SETTLE_CYCLES = DEF_SETTLE_CYCLES,
    parameter int                       TIMEOUT_WIDTH = DEF_TIMEOUT_WIDTH,
    parameter logic [TIMEOUT_WIDTH-1:0] LOCK_TIMEOUT  = TIMEOUT_WIDTH'(DEF_LOCK_TIMEOUT)
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic [PLL_DATA_WIDTH-1:0] req_data,
    input  logic                      req_switch,
    output logic                      busy,
    output logic                      done,
    output logic                      error,
    output logic                      lock_lost,
    output logic                      pll_reset,
    output logic [PLL_DATA_WIDTH-1:0] pll_data,
    output logic                      pll_trigger,
    output logic                      pll_switch,
    input  logic                      pll_locked
);

    // One counter width serves the hold, settle and timeout counts.
    localparam int CNT_W = max_int(TIMEOUT_WIDTH,
                                   $clog2(max_int(RESET_CYCLES, SETTLE_CYCLES) + 1));
    localparam logic [CNT_W-1:0] RST_LAST   = CNT_W'(RESET_CYCLES - 1);
    localparam logic [CNT_W-1:0] SETTLE_LIM = CNT_W'(SETTLE_CYCLES);
    localparam logic [CNT_W-1:0] TMO_LAST   = CNT_W'(LOCK_TIMEOUT) - CNT_W'(1);

    state_t                    state_r, state_s;
    logic [CNT_W-1:0]          cnt_r, cnt_s;
    logic [CNT_W-1:0]          settle_r, settle_s;
    logic [PLL_DATA_WIDTH-1:0] data_r;
    logic                      switch_cap_r;
    logic                      switch_r;
    logic                      trigger_r;
    logic                      pll_reset_r;
    logic                      done_r;
    logic                      error_r;
    logic                      ready_r;
    logic                      busy_r;
    logic                      lock_lost_r;
    logic                      configured_r;
    logic                      lock_sync_s;
    logic                      accept_s;

    sync_2ff #(.WIDTH(1)) u_lock_sync (
        .clock (clock),
        .reset (reset),
        .d     (pll_locked),
        .q     (lock_sync_s)
    );

    assign accept_s = req_valid & (state_r == S_IDLE);

    // Next-state and counter update; counters saturate at their limits.
    always_comb begin
        state_s  = state_r;
        cnt_s    = {CNT_W{1'b0}};
        settle_s = {CNT_W{1'b0}};
        case (state_r)
            S_IDLE: begin
                if (accept_s) begin
                    state_s = S_LOAD;
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_LOAD:    state_s = S_TRIGGER;
            S_TRIGGER: state_s = S_HOLD_RST;
            S_HOLD_RST: begin
                if (cnt_r >= RST_LAST) begin
                    state_s = S_WAIT_LOCK;
                end else begin
                    cnt_s = cnt_r + CNT_W'(1);
                end
            end
            S_WAIT_LOCK: begin
                if (cnt_r < TMO_LAST) begin
                    cnt_s = cnt_r + CNT_W'(1);
                end else begin
                    cnt_s = cnt_r;
                end
                if (!lock_sync_s) begin
                    settle_s = {CNT_W{1'b0}};
                end else if (settle_r < SETTLE_LIM) begin
                    settle_s = settle_r + CNT_W'(1);
                end else begin
                    settle_s = settle_r;
                end
                // A completed settle takes priority over an expiring timeout.
                if (settle_r >= SETTLE_LIM) begin
                    state_s = S_DONE;
                end else if (cnt_r >= TMO_LAST) begin
                    state_s = S_FAIL;
                end else begin
                    state_s = S_WAIT_LOCK;
                end
            end
            S_DONE:  state_s = S_IDLE;
            S_FAIL:  state_s = S_IDLE;
            default: state_s = S_IDLE;
        endcase
    end

    // State, counters and registered outputs decoded from the next state.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r      <= S_IDLE;
            cnt_r        <= {CNT_W{1'b0}};
            settle_r     <= {CNT_W{1'b0}};
            data_r       <= {PLL_DATA_WIDTH{1'b0}};
            switch_cap_r <= 1'b0;
            switch_r     <= 1'b0;
            trigger_r    <= 1'b0;
            pll_reset_r  <= 1'b0;
            done_r       <= 1'b0;
            error_r      <= 1'b0;
            ready_r      <= 1'b1;
            busy_r       <= 1'b0;
            lock_lost_r  <= 1'b0;
            configured_r <= 1'b0;
        end else begin
            state_r     <= state_s;
            cnt_r       <= cnt_s;
            settle_r    <= settle_s;
            trigger_r   <= (state_s == S_TRIGGER);
            pll_reset_r <= (state_s == S_HOLD_RST);
            done_r      <= (state_s == S_DONE);
            error_r     <= (state_s == S_FAIL);
            ready_r     <= (state_s == S_IDLE);
            busy_r      <= (state_s != S_IDLE);
            if (accept_s) begin
                data_r       <= req_data;
                switch_cap_r <= req_switch;
            end
            if (state_r == S_TRIGGER) begin
                switch_r <= switch_cap_r;
            end
            if (state_r == S_DONE) begin
                configured_r <= 1'b1;
            end else if (state_r == S_FAIL) begin
                configured_r <= 1'b0;
            end
            if (accept_s) begin
                lock_lost_r <= 1'b0;
            end else if ((state_r == S_IDLE) && configured_r && !lock_sync_s) begin
                lock_lost_r <= 1'b1;
            end
        end
    end

    assign req_ready   = ready_r;
    assign busy        = busy_r;
    assign done        = done_r;
    assign error       = error_r;
    assign lock_lost   = lock_lost_r;
    assign pll_reset   = pll_reset_r;
    assign pll_data    = data_r;
    assign pll_trigger = trigger_r;
    assign pll_switch  = switch_r;

endmodule

// File: tb/tb_pll_reconfig_ctrl.sv
// Directed bench for pll_reconfig_ctrl with RESET_CYCLES=8, SETTLE_CYCLES=4
// and a short LOCK_TIMEOUT of 20 so the timeout path is reachable.
module tb_pll_reconfig_ctrl;

    logic        clock = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [15:0] req_data;
    logic        req_switch;
    logic        busy;
    logic        done;
    logic        error;
    logic        lock_lost;
    logic        pll_reset;
    logic [15:0] pll_data;
    logic        pll_trigger;
    logic        pll_switch;
    logic        pll_locked;

    int n_checks = 0;
    int n_errors = 0;

    pll_reconfig_ctrl #(
        .RESET_CYCLES  (8),
        .SETTLE_CYCLES (4),
        .TIMEOUT_WIDTH (16),
        .LOCK_TIMEOUT  (16'd20)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_data    (req_data),
        .req_switch  (req_switch),
        .busy        (busy),
        .done        (done),
        .error       (error),
        .lock_lost   (lock_lost),
        .pll_reset   (pll_reset),
        .pll_data    (pll_data),
        .pll_trigger (pll_trigger),
        .pll_switch  (pll_switch),
        .pll_locked  (pll_locked)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_checks++;
        assert (observed === expected)
        else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Advance to 1 time unit after the next rising edge.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset      = 1'b1;
        req_valid  = 1'b0;
        req_data   = 16'h0000;
        req_switch = 1'b0;
        pll_locked = 1'b0;
        step(); step(); step();

        // Reset state
        chk("rst_ready",   {31'd0, req_ready},   32'd1);
        chk("rst_busy",    {31'd0, busy},        32'd0);
        chk("rst_done",    {31'd0, done},        32'd0);
        chk("rst_error",   {31'd0, error},       32'd0);
        chk("rst_lost",    {31'd0, lock_lost},   32'd0);
        chk("rst_preset",  {31'd0, pll_reset},   32'd0);
        chk("rst_data",    {16'd0, pll_data},    32'd0);
        chk("rst_trig",    {31'd0, pll_trigger}, 32'd0);
        chk("rst_switch",  {31'd0, pll_switch},  32'd0);
        reset = 1'b0;
        step();

        // Nominal: accept A5C3/switch=1, lock rises 5 cycles after pll_reset falls
        req_data = 16'hA5C3; req_switch = 1'b1; req_valid = 1'b1;
        step(); req_valid = 1'b0;                               // cycle 1
        chk("nom_load_data", {16'd0, pll_data}, 32'h0000A5C3);
        chk("nom_load_busy", {31'd0, busy}, 32'd1);
        chk("nom_load_rdy",  {31'd0, req_ready}, 32'd0);
        chk("nom_load_trig", {31'd0, pll_trigger}, 32'd0);
        step();                                                 // cycle 2
        chk("nom_trig",      {31'd0, pll_trigger}, 32'd1);
        chk("nom_trig_data", {16'd0, pll_data}, 32'h0000A5C3);
        chk("nom_trig_prst", {31'd0, pll_reset}, 32'd0);
        chk("nom_trig_sw",   {31'd0, pll_switch}, 32'd0);
        for (int c = 3; c <= 10; c++) begin
            step();
            chk("nom_hold_prst", {31'd0, pll_reset}, 32'd1);
            chk("nom_hold_sw",   {31'd0, pll_switch}, 32'd1);
            chk("nom_hold_trig", {31'd0, pll_trigger}, 32'd0);
        end
        for (int c = 11; c <= 22; c++) begin
            step();
            chk("nom_wait_prst", {31'd0, pll_reset}, 32'd0);
            chk("nom_wait_done", {31'd0, done}, 32'd0);
            chk("nom_wait_err",  {31'd0, error}, 32'd0);
            if (c == 16) pll_locked = 1'b1;
        end
        step();                                                 // cycle 23
        chk("nom_done",     {31'd0, done}, 32'd1);
        chk("nom_done_err", {31'd0, error}, 32'd0);
        step();                                                 // cycle 24
        chk("nom_after_done", {31'd0, done}, 32'd0);
        chk("nom_after_rdy",  {31'd0, req_ready}, 32'd1);
        chk("nom_after_busy", {31'd0, busy}, 32'd0);
        chk("nom_after_data", {16'd0, pll_data}, 32'h0000A5C3);
        chk("nom_after_sw",   {31'd0, pll_switch}, 32'd1);

        // Lock loss after success
        pll_locked = 1'b0;
        step();                                                 // cycle 25
        chk("lost_early", {31'd0, lock_lost}, 32'd0);
        step(); step();                                         // cycle 27
        chk("lost_set", {31'd0, lock_lost}, 32'd1);
        step(); step();                                         // cycle 29
        chk("lost_held", {31'd0, lock_lost}, 32'd1);

        // Timeout: lock stays low, LOCK_TIMEOUT=20
        req_data = 16'h0F0F; req_switch = 1'b0; req_valid = 1'b1;
        step(); req_valid = 1'b0;                               // cycle 1
        chk("tmo_lost_clr", {31'd0, lock_lost}, 32'd0);
        for (int c = 2; c <= 30; c++) begin
            step();
            chk("tmo_wait_err",  {31'd0, error}, 32'd0);
            chk("tmo_wait_done", {31'd0, done}, 32'd0);
        end
        step();                                                 // cycle 31
        chk("tmo_err",      {31'd0, error}, 32'd1);
        chk("tmo_err_done", {31'd0, done}, 32'd0);
        step();                                                 // cycle 32
        chk("tmo_err_once", {31'd0, error}, 32'd0);
        chk("tmo_rdy",      {31'd0, req_ready}, 32'd1);
        chk("tmo_data",     {16'd0, pll_data}, 32'h00000F0F);
        chk("tmo_sw",       {31'd0, pll_switch}, 32'd0);
        chk("tmo_lost",     {31'd0, lock_lost}, 32'd0);
        step();

        // Glitchy lock: high 3, low 1, then steady high
        req_data = 16'h3C3C; req_switch = 1'b1; req_valid = 1'b1;
        step(); req_valid = 1'b0;                               // cycle 1
        for (int c = 2; c <= 21; c++) begin
            step();
            chk("gl_no_done", {31'd0, done}, 32'd0);
            if (c == 11) pll_locked = 1'b1;
            if (c == 14) pll_locked = 1'b0;
            if (c == 15) pll_locked = 1'b1;
        end
        step();                                                 // cycle 22
        chk("gl_done",    {31'd0, done}, 32'd1);
        chk("gl_no_err",  {31'd0, error}, 32'd0);
        step();

        // Back-to-back with req_valid held; lock already high
        req_data = 16'h1234; req_switch = 1'b0; req_valid = 1'b1;
        step();                                                 // cycle 1
        chk("b2b_data1", {16'd0, pll_data}, 32'h00001234);
        req_data = 16'h5678; req_switch = 1'b1;
        for (int c = 2; c <= 15; c++) begin
            step();
            chk("b2b_busy_done", {31'd0, done}, 32'd0);
            chk("b2b_busy_rdy",  {31'd0, req_ready}, 32'd0);
        end
        step();                                                 // cycle 16
        chk("b2b_done1",     {31'd0, done}, 32'd1);
        chk("b2b_done1_dat", {16'd0, pll_data}, 32'h00001234);
        step();                                                 // cycle 17
        chk("b2b_rdy",       {31'd0, req_ready}, 32'd1);
        chk("b2b_rdy_dat",   {16'd0, pll_data}, 32'h00001234);
        step();                                                 // cycle 18
        chk("b2b_data2",     {16'd0, pll_data}, 32'h00005678);
        chk("b2b_busy2",     {31'd0, busy}, 32'd1);
        req_valid = 1'b0;
        for (int c = 19; c <= 32; c++) begin
            step();
            chk("b2b_wait_done", {31'd0, done}, 32'd0);
            req_valid = (c == 21);
            req_data  = 16'hDEAD;
        end
        step();                                                 // cycle 33
        chk("b2b_done2",     {31'd0, done}, 32'd1);
        chk("b2b_done2_dat", {16'd0, pll_data}, 32'h00005678);
        chk("b2b_done2_sw",  {31'd0, pll_switch}, 32'd1);
        step();                                                 // cycle 34
        chk("b2b_idle_rdy",  {31'd0, req_ready}, 32'd1);
        chk("b2b_idle_busy", {31'd0, busy}, 32'd0);
        step();                                                 // cycle 35
        chk("b2b_drop_busy", {31'd0, busy}, 32'd0);
        chk("b2b_drop_dat",  {16'd0, pll_data}, 32'h00005678);

        // Reset during HOLD_RST
        req_data = 16'h7777; req_switch = 1'b0; req_valid = 1'b1;
        step(); req_valid = 1'b0;                               // cycle 1
        step(); step(); step(); step();                         // cycle 5
        chk("mid_hold_prst", {31'd0, pll_reset}, 32'd1);
        reset = 1'b1;
        #1;
        chk("mid_rst_prst", {31'd0, pll_reset}, 32'd0);
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        chk("mid_rst_data", {16'd0, pll_data}, 32'd0);
        chk("mid_rst_rdy",  {31'd0, req_ready}, 32'd1);
        step(); step();
        reset = 1'b0;
        for (int c = 0; c < 30; c++) begin
            step();
            chk("post_rst_rdy",  {31'd0, req_ready}, 32'd1);
            chk("post_rst_done", {31'd0, done}, 32'd0);
            chk("post_rst_err",  {31'd0, error}, 32'd0);
        end
        chk("post_rst_lost", {31'd0, lock_lost}, 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
